sumsq_128b: RTL and testbench
=============================

# sumsq_128b

Sequential sum-of-squares stage that computes x² + y² for two unsigned W-bit components and presents the result as a 128-bit radicand. It sits directly upstream of the 128-bit integer square-root stage: out0 drives that stage's in0, so the pair forms a vector-magnitude path. Arithmetic is a shift-add multiplier that retires one multiplier bit per cycle. Input and output use valid/ready handshakes.

## Interface
- W, default 63: component width; legal range 1..63, so that 2W+1 ≤ 128 and the sum never overflows.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_x/in_y valid.
- in_ready  out  1  block can accept an operand pair.
- in_x  in  W  unsigned component x.
- in_y  in  W  unsigned component y.
- out_valid  out  1  out0 holds a result.
- out_ready  in  1  consumer accepts out0.
- out0  out  128  x² + y², zero-extended, unsigned.

## Operation
- FSM states and transitions:
  - IDLE to MUL_X on accept (in_valid & in_ready).
  - MUL_X to MUL_Y after W steps.
  - MUL_Y to DONE after W steps.
  - DONE to IDLE on out_valid & out_ready.
- Internal registers:
  - mcand: 2W bits, multiplicand.
  - mplier: W bits, multiplier.
  - acc: 128 bits, accumulator.
  - cnt: enough bits to hold W-1, step counter.
  - yreg: W bits, holds the captured y.
  - res: 128 bits, result register.
- Accept edge:
  - mcand ← zero-extended in_x; mplier ← in_x.
  - yreg ← in_y; acc ← 0; cnt ← 0.
- Step (each clock in MUL_X/MUL_Y):
  - If mplier[0], then acc ← acc + mcand (mcand zero-extended to 128).
  - mcand ← mcand << 1; mplier ← mplier >> 1; cnt ← cnt + 1.
- MUL_X to MUL_Y transition:
  - Happens on the step where cnt == W-1.
  - That step's add is performed.
  - In the same edge, reload mcand ← yreg, mplier ← yreg, cnt ← 0.
  - acc is kept.
- MUL_Y to DONE transition:
  - Happens on the step where cnt == W-1; that step's add is performed.
  - res ← final acc (acc + conditional mcand) on the same edge.
- in_ready is 1 only in IDLE. out_valid is 1 only in DONE. out0 = res at all times.
- res keeps its value until the next DONE entry. It is not cleared on the output handshake.
- The block does no early termination. Latency is independent of operand values.
- No overflow is possible within the legal range of W. Maximum result: 2(2^W−1)².

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE; all registers 0.
  - Outputs: in_ready = 1, out_valid = 0, out0 = 0.
- Reset mid-operation: the transaction in flight is dropped and no partial result appears. Operation resumes on the first rising edge after rst_n goes high.
- Accept at edge T: in_ready goes low in the following cycle.
- Compute: MUL_X covers edges T+1..T+W; MUL_Y covers edges T+W+1..T+2W.
- Output: out_valid rises after edge T+2W, a latency of 2W cycles (126 at the default). out0 is valid in that same cycle.
- Backpressure: while out_valid = 1 and out_ready = 0, out_valid and out0 hold stable and in_ready stays 0.
- Output handshake at edge D: out_valid = 0 and in_ready = 1 from the following cycle. The next accept can happen no earlier than edge D+1.
- Throughput is at most 1 result per 2W+2 cycles.
- in_valid while in_ready = 0 is ignored; in_x/in_y are not sampled.
- out_ready while out_valid = 0 has no effect.

## Test plan
- Basic: x=3, y=4 accepted at edge T, out_ready=1 → out_valid=1 exactly 126 cycles after T, out0=25, one cycle of valid, then in_ready=1.
- Max operands: x=y=2^63−1 → out0=0x7FFFFFFFFFFFFFFE0000000000000002.
- Zero operands: x=0, y=0 → out0=0, same 126-cycle latency. Asymmetric: x=0, y=0x7FFFFFFFFFFFFFFF → out0=0x3FFFFFFFFFFFFFFF0000000000000001.
- Backpressure: x=5, y=12, out_ready held 0 for 10 cycles after out_valid → out_valid=1 and out0=169 stable throughout, in_ready=0, extra in_valid pulses ignored. Then out_ready=1 → handshake, and in_ready=1 the next cycle.
- Reset mid-operation: pull rst_n low for 2 cycles, 50 cycles after accepting x=7, y=9 → out_valid=0, out0=0, in_ready=1 immediately. A following transaction x=1, y=1 → out0=2.
- Back-to-back: in_valid held high with pairs (1,2), (6,8), out_ready=1 → results 5 then 100. The second pair is accepted on the edge after the first output handshake, and its result appears 126 cycles later.

Source files
------------

// File: rtl/sumsq_128b_if.sv
// Handshake bundle for the sum-of-squares stage.
// Operand side:  in_valid / in_ready with in_x, in_y (W-bit unsigned).
// Result side:   out_valid / out_ready with out0 (128-bit unsigned x^2 + y^2).
// master: the producer/consumer around the block; slave: the block itself.
interface sumsq_128b_if #(
    parameter int unsigned W = 63
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_x;
    logic [W-1:0]  in_y;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out0;

    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out0
    );

    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out0
    );
endinterface

// File: rtl/sumsq_128b.sv
// Sequential sum-of-squares stage: out0 = x^2 + y^2 as a 128-bit radicand.
// Shift-add multiplier retiring one multiplier bit per clock; x^2 is formed
// first, then y^2 is accumulated on top. Fixed latency of 2W cycles.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of sumsq_128b_if (operand and result handshakes)
module sumsq_128b #(
    parameter int unsigned W = 63
) (
    input  logic         clk,
    input  logic         rst_n,
    sumsq_128b_if.slave  bus
);

    localparam int unsigned RES_W = 128;
    localparam int unsigned MC_W  = 2 * W;
    localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_X = 2'd1,
        MUL_Y = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q,     state_d;
    logic [MC_W-1:0]    mcand_q,     mcand_d;
    logic [W-1:0]       mplier_q,    mplier_d;
    logic [RES_W-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [W-1:0]       yreg_q,      yreg_d;
    logic [RES_W-1:0]   res_q,       res_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [RES_W-1:0]   acc_step;
    logic               last_step;

    // Accumulator value after this cycle's conditional add.
    assign acc_step  = acc_q + (mplier_q[0] ? RES_W'(mcand_q) : RES_W'(0));
    assign last_step = (cnt_q == CNT_LAST);

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        yreg_d   = yreg_q;
        res_d    = res_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    state_d  = MUL_X;
                    mcand_d  = MC_W'(bus.in_x);
                    mplier_d = bus.in_x;
                    yreg_d   = bus.in_y;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            MUL_X: begin
                acc_d = acc_step;
                if (last_step) begin
                    // Second pass reuses the same shifter for y^2; acc carries x^2.
                    state_d  = MUL_Y;
                    mcand_d  = MC_W'(yreg_q);
                    mplier_d = yreg_q;
                    cnt_d    = '0;
                end else begin
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            MUL_Y: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (last_step) begin
                    state_d = DONE;
                    res_d   = acc_step;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            yreg_q      <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            yreg_q      <= yreg_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out0      = res_q;

endmodule

// File: tb/tb_sumsq_128b.sv
// Self-checking bench for sumsq_128b: directed corner cases plus random
// operand pairs, compared against plain 128-bit arithmetic x*x + y*y.
module tb_sumsq_128b;

    localparam int unsigned W   = 63;
    localparam int unsigned LAT = 2 * W;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    sumsq_128b_if #(.W(W)) bus ();

    sumsq_128b #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] sumsq_ref(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [127:0] xx;
        logic [127:0] yy;
        xx = 128'(x);
        yy = 128'(y);
        return xx * xx + yy * yy;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operand pair and complete the accept edge; in_valid drops unless keep.
    task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y, input bit keep);
        int waited;
        waited = 0;
        while (!bus.in_ready && waited < 4 * LAT) begin
            tick();
            waited++;
        end
        if (!bus.in_ready) chk("accept_timeout", 128'(bus.in_ready), 128'(1));
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_y     = y;
        tick();
        if (!keep) bus.in_valid = 1'b0;
        chk("in_ready_after_accept", 128'(bus.in_ready), 128'(0));
    endtask

    // Called right after the accept edge: checks latency, value, backpressure and handshake.
    task automatic expect_result(input string tag, input logic [127:0] exp, input int hold);
        int          cyc;
        logic [127:0] held;
        bit          early;
        cyc   = 0;
        early = 0;
        bus.out_ready = (hold == 0);
        while (!bus.out_valid && cyc < 4 * LAT) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 128'(cyc), 128'(LAT));
        chk({tag, "_value"}, bus.out0, exp);
        chk({tag, "_in_ready_busy"}, 128'(bus.in_ready), 128'(0));
        held = bus.out0;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.in_x     = W'({$urandom, $urandom});
            bus.in_y     = W'({$urandom, $urandom});
            tick();
            if (!bus.out_valid || bus.out0 !== held || bus.in_ready) early = 1;
        end
        if (hold > 0) begin
            chk({tag, "_backpressure_stable"}, 128'(early), 128'(0));
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        tick();
        chk({tag, "_out_valid_after_hs"}, 128'(bus.out_valid), 128'(0));
        chk({tag, "_in_ready_after_hs"}, 128'(bus.in_ready), 128'(1));
        chk({tag, "_res_held"}, bus.out0, exp);
    endtask

    initial begin
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic [W-1:0] wmax;
        n_cmp = 0;
        n_err = 0;
        wmax  = '1;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_out0", bus.out0, 128'(0));
        rst_n = 1'b1;
        tick();

        accept(W'(3), W'(4), 0);
        expect_result("basic", 128'd25, 0);

        accept(wmax, wmax, 0);
        expect_result("max", 128'h7FFFFFFFFFFFFFFE0000000000000002, 0);

        accept(W'(0), W'(0), 0);
        expect_result("zero", 128'd0, 0);

        accept(W'(0), wmax, 0);
        expect_result("asym", 128'h3FFFFFFFFFFFFFFF0000000000000001, 0);

        accept(W'(5), W'(12), 0);
        expect_result("bp", 128'd169, 10);

        // Reset mid-operation drops the transaction without exposing partial state.
        accept(W'(7), W'(9), 0);
        for (int i = 0; i < 50; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("midrst_out0", bus.out0, 128'(0));
        chk("midrst_in_ready", 128'(bus.in_ready), 128'(1));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        accept(W'(1), W'(1), 0);
        expect_result("post_rst", 128'd2, 0);

        // Back-to-back: in_valid stays high; second pair is taken on the edge after the handshake.
        accept(W'(1), W'(2), 1);
        bus.in_x = W'(6);
        bus.in_y = W'(8);
        expect_result("b2b_first", 128'd5, 0);
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_second_accepted", 128'(bus.in_ready), 128'(0));
        expect_result("b2b_second", 128'd100, 0);

        for (int n = 0; n < 8; n++) begin
            rx = W'({$urandom, $urandom});
            ry = W'({$urandom, $urandom});
            if (n == 0) ry = wmax;
            accept(rx, ry, 0);
            expect_result($sformatf("rand%0d", n), sumsq_ref(rx, ry), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
